// File: rtl/cellrv32_cpu_cp_vector_iq_pkg.sv
// cellrv32_package slice: vector instruction bundle and queue depth.
// Queue bypass is selected with CELLRV32_VIQ_BYPASS_EN.
package cellrv32_package;

  localparam int vector_iq_depth_c = 4;

  typedef struct packed {
    logic        reconfigure;
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] rs1_data;
  } to_vector;

endpackage

// File: rtl/cellrv32_cpu_cp_vector_iq_mem.sv
// Vector IQ storage: one write port, async read, reset to zero.
// Used by cellrv32_cpu_cp_vector_iq (CELLRV32_VIQ_BYPASS_EN aware top).
module cellrv32_cpu_cp_vector_iq_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cellrv32_cpu_cp_vector_iq.sv
// Vector instruction queue with reconfigure fence.
// Define CELLRV32_VIQ_BYPASS_EN for zero-latency pass-through when empty.
module cellrv32_cpu_cp_vector_iq
  import cellrv32_package::*;
#(
  parameter int DEPTH = vector_iq_depth_c,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           flush_i,
  input  logic           push_valid_i,
  input  to_vector       push_instr_i,
  output logic           push_ready_o,
  output logic           valid_o,
  output to_vector       instr_o,
  input  logic           pop_i,
  input  logic           downstream_busy_i,
  output logic [PTR_W:0] count_o,
  output logic           is_idle_o
);

  localparam logic [PTR_W:0]   FULL_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             empty, push_acc, pop_acc;
  logic             have, byp, fence;
  logic             wr_en, rd_adv;
  to_vector         rd_data;

  assign empty        = (count == '0);
  assign push_ready_o = (count < FULL_C);
  assign push_acc     = push_valid_i & push_ready_o & ~flush_i;

`ifdef CELLRV32_VIQ_BYPASS_EN
  assign byp     = empty & push_acc;
  assign have    = ~empty | byp;
  assign instr_o = byp ? push_instr_i : rd_data;
`else
  assign byp     = 1'b0;
  assign have    = ~empty;
  assign instr_o = rd_data;
`endif

  assign fence   = instr_o.reconfigure & downstream_busy_i;
  assign valid_o = have & ~flush_i & ~fence;
  assign pop_acc = pop_i & valid_o;

  // A bypassed entry consumed in its push cycle never touches storage
  assign wr_en  = push_acc & ~(byp & pop_acc);
  assign rd_adv = pop_acc & ~byp;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, rd_adv})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  cellrv32_cpu_cp_vector_iq_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(to_vector))
  ) u_mem (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .we     (wr_en),
    .waddr  (wr_ptr),
    .wdata  (push_instr_i),
    .raddr  (rd_ptr),
    .rdata  (rd_data)
  );

  assign count_o   = count;
  assign is_idle_o = empty & ~push_valid_i;

endmodule

// File: tb/tb_cellrv32_cpu_cp_vector_iq.sv
// Directed bench for the vector instruction queue.
// Expectations follow CELLRV32_VIQ_BYPASS_EN when it is defined.
module tb_cellrv32_cpu_cp_vector_iq;
  import cellrv32_package::*;

  logic     clk = 1'b0;
  logic     rstn = 1'b0;
  logic     flush = 1'b0;
  logic     push_valid = 1'b0;
  to_vector push_instr = '0;
  logic     push_ready;
  logic     valid;
  to_vector instr;
  logic     pop = 1'b0;
  logic     busy = 1'b0;
  logic [2:0] count;
  logic     idle;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  bit byp;

  cellrv32_cpu_cp_vector_iq #(.DEPTH(4)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .flush_i           (flush),
    .push_valid_i      (push_valid),
    .push_instr_i      (push_instr),
    .push_ready_o      (push_ready),
    .valid_o           (valid),
    .instr_o           (instr),
    .pop_i             (pop),
    .downstream_busy_i (busy),
    .count_o           (count),
    .is_idle_o         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic to_vector mk(input int tag, input bit rc);
    to_vector v;
    v = '0;
    v.reconfigure = rc;
    v.rs1_data = 32'(tag);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
`ifdef CELLRV32_VIQ_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    #2;
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_ready", push_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_instr", instr, 0);
    #10 rstn = 1'b1;
    tick;

    // push A,B,C
    push_valid = 1; push_instr = mk(1, 0);
    settle;
    check("a_idle", idle, 0);
    check("a_valid_push_cycle", valid, byp);
    tick;
    check("a_count", count, 1);
    push_instr = mk(2, 0);
    settle;
    check("a_valid", valid, 1);
    check("a_head", instr.rs1_data, 1);
    tick;
    check("b_count", count, 2);
    push_instr = mk(3, 0);
    tick;
    check("c_count", count, 3);
    check("c_head", instr.rs1_data, 1);

    // fill to DEPTH, then push while popping at full
    push_instr = mk(4, 0);
    tick;
    check("full_count", count, 4);
    push_instr = mk(5, 0); pop = 1;
    settle;
    check("full_ready", push_ready, 0);
    check("full_head", instr.rs1_data, 1);
    tick;
    check("full_pop_count", count, 3);
    pop = 0;
    settle;
    check("resume_ready", push_ready, 1);
    check("resume_head", instr.rs1_data, 2);
    tick;
    check("refill_count", count, 4);
    push_valid = 0; pop = 1;
    tick;
    pop = 0;
    check("drop1_count", count, 3);
    exp_q = '{3, 4, 5};

    // streaming push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push_valid = 1; push_instr = mk(20 + i, 0); pop = 1;
      settle;
      check("stream_head", instr.rs1_data, 64'(exp_q[0]));
      check("stream_count", count, 3);
      tick;
      void'(exp_q.pop_front());
      exp_q.push_back(20 + i);
    end
    push_valid = 0; pop = 0;
    settle;
    check("stream_end_head", instr.rs1_data, 64'(exp_q[0]));

    // flush with a push offered
    flush = 1; push_valid = 1; push_instr = mk(40, 0);
    settle;
    check("flush_valid", valid, 0);
    tick;
    flush = 0; push_valid = 0;
    settle;
    check("flush_count", count, 0);
    check("flush_valid_after", valid, 0);
    check("flush_idle", idle, 1);
    push_valid = 1; push_instr = mk(41, 0);
    tick;
    push_valid = 0; pop = 1;
    settle;
    check("post_flush_head", instr.rs1_data, 41);
    check("post_flush_count", count, 1);
    tick;
    pop = 0;

    // reconfigure fence
    busy = 1; push_valid = 1; push_instr = mk(50, 1);
    settle;
    check("fence_push_valid", valid, 0);
    tick;
    push_valid = 0; pop = 1;
    for (int i = 0; i < 5; i++) begin
      settle;
      check("fence_valid", valid, 0);
      check("fence_count", count, 1);
      tick;
    end
    busy = 0;
    settle;
    check("fence_release", valid, 1);
    check("fence_head_rc", instr.reconfigure, 1);
    tick;
    pop = 0;
    check("fence_popped", count, 0);
    push_valid = 1; push_instr = mk(51, 0);
    tick;
    push_valid = 0; busy = 1;
    settle;
    check("nofence_valid", valid, 1);
    pop = 1;
    tick;
    pop = 0; busy = 0;
    check("nofence_popped", count, 0);

    // empty queue, push and pop together
    push_valid = 1; push_instr = mk(60, 0); pop = 1;
    settle;
    check("byp_valid", valid, byp);
    if (byp) check("byp_instr", instr.rs1_data, 60);
    tick;
    push_valid = 0;
    settle;
    check("byp_count", count, byp ? 0 : 1);
    check("byp_next_valid", valid, !byp);
    if (!byp) check("nobyp_next_instr", instr.rs1_data, 60);
    tick;
    check("byp_drain", count, 0);
    tick;
    pop = 0;
    check("empty_pop_ignored", count, 0);
    push_valid = 1; push_instr = mk(61, 0);
    tick;
    push_valid = 0;
    check("after_empty_pop_head", instr.rs1_data, 61);

    // async reset mid-operation
    push_valid = 1; push_instr = mk(62, 0);
    tick;
    push_valid = 0;
    #2 rstn = 0;
    #1;
    check("arst_count", count, 0);
    check("arst_valid", valid, 0);
    check("arst_instr", instr, 0);
    check("arst_ready", push_ready, 1);
    #5 rstn = 1;
    tick;
    check("arst_idle", idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
